// File: rtl/r2sdf_fix_stage.sv
// r2sdf_fix_stage: one fixed-point radix-2 single-path delay-feedback butterfly stage of a 2^N-point FFT.
// Optional: define R2SDF_OVF_FLAG_EN to add the sticky saturation flag output ovf_o.
`timescale 1ns/1ps
module r2sdf_fix_stage #(
  parameter int unsigned N     = 3,
  parameter int unsigned STAGE = 1,
  parameter int unsigned DW    = 16,
  parameter int unsigned TW    = 16,
  parameter int unsigned SCALE = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  input  logic                 in_sof_i,
  input  logic signed [DW-1:0] in_re_i,
  input  logic signed [DW-1:0] in_im_i,
  output logic        [N-2:0]  tw_addr_o,
  input  logic signed [TW-1:0] tw_re_i,
  input  logic signed [TW-1:0] tw_im_i,
  output logic                 out_valid_o,
  output logic                 out_sof_o,
  output logic signed [DW-1:0] out_re_o,
  output logic signed [DW-1:0] out_im_o
`ifdef R2SDF_OVF_FLAG_EN
  ,
  output logic                 ovf_o
`endif
);

  localparam int unsigned DELAY = 1 << (N - STAGE);
  localparam int unsigned CW    = N - STAGE + 1;
  localparam int unsigned BW    = (STAGE > 1) ? STAGE - 1 : 1;
  localparam int unsigned SW    = DW + 1;
  localparam int unsigned PW    = DW + TW + 1;
  localparam logic signed [PW-1:0] MAXV = PW'({1'b0, {(DW-1){1'b1}}});
  localparam logic signed [PW-1:0] MINV = -MAXV - PW'(1);
  localparam logic signed [PW-1:0] RND  = PW'(1) << (TW - 2);

  function automatic logic signed [DW-1:0] sat_dw(input logic signed [PW-1:0] x);
    if (x > MAXV)      sat_dw = DW'(MAXV);
    else if (x < MINV) sat_dw = DW'(MINV);
    else               sat_dw = DW'(x);
  endfunction

  // Butterfly output: rounded halving when scaling, otherwise clamp to DW.
  function automatic logic signed [DW-1:0] fold(input logic signed [SW-1:0] x);
    logic signed [SW:0] t;
    t = (SW+1)'(x) + (SW+1)'(1);
    if (SCALE != 0) fold = DW'(t >>> 1);
    else            fold = sat_dw(PW'(x));
  endfunction

  logic [CW-1:0]        cnt_q, cnt_d, cnt_e;
  logic [BW-1:0]        blk_q, blk_d, blk_e, blk_rev;
  logic                 primed_q, primed_d;
  logic signed [DW-1:0] dl_re_q [DELAY];
  logic signed [DW-1:0] dl_re_d [DELAY];
  logic signed [DW-1:0] dl_im_q [DELAY];
  logic signed [DW-1:0] dl_im_d [DELAY];
  logic                 out_valid_q, out_valid_d, out_sof_q, out_sof_d;
  logic signed [DW-1:0] out_re_q, out_re_d, out_im_q, out_im_d;

  logic                 bf, use_tw;
  logic signed [PW-1:0] pr_full, pi_full;
  logic signed [DW-1:0] p_re, p_im, head_re, head_im;
  logic signed [SW-1:0] s_re, s_im, d_re, d_im;

  for (genvar g = 0; g < BW; g++) begin : g_rev
    if (STAGE > 1) begin : g_on
      assign blk_rev[g] = blk_q[BW-1-g];
    end else begin : g_off
      assign blk_rev[g] = 1'b0;
    end
  end

  assign tw_addr_o = (N-1)'(blk_rev) << (N - STAGE);

  // A frame-start sample restarts the position counters for itself.
  always_comb begin
    cnt_e   = in_sof_i ? '0 : cnt_q;
    blk_e   = in_sof_i ? '0 : blk_q;
    bf      = cnt_e[CW-1];
    use_tw  = bf && (tw_addr_o != '0);
    head_re = dl_re_q[DELAY-1];
    head_im = dl_im_q[DELAY-1];
    pr_full = PW'(in_re_i) * PW'(tw_re_i) - PW'(in_im_i) * PW'(tw_im_i) + RND;
    pi_full = PW'(in_re_i) * PW'(tw_im_i) + PW'(in_im_i) * PW'(tw_re_i) + RND;
    p_re    = use_tw ? sat_dw(pr_full >>> (TW - 1)) : in_re_i;
    p_im    = use_tw ? sat_dw(pi_full >>> (TW - 1)) : in_im_i;
    s_re    = SW'(head_re) + SW'(p_re);
    s_im    = SW'(head_im) + SW'(p_im);
    d_re    = SW'(head_re) - SW'(p_re);
    d_im    = SW'(head_im) - SW'(p_im);
  end

  always_comb begin
    cnt_d       = cnt_q;
    blk_d       = blk_q;
    primed_d    = primed_q;
    dl_re_d     = dl_re_q;
    dl_im_d     = dl_im_q;
    out_valid_d = 1'b0;
    out_sof_d   = 1'b0;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    if (in_valid_i) begin
      cnt_d       = cnt_e + CW'(1);
      blk_d       = (STAGE > 1 && cnt_e == '1) ? blk_e + BW'(1) : blk_e;
      primed_d    = primed_q | bf;
      out_valid_d = primed_q | bf;
      out_sof_d   = (cnt_e == CW'(DELAY)) && (blk_e == '0);
      for (int i = 1; i < int'(DELAY); i++) begin
        dl_re_d[i] = dl_re_q[i-1];
        dl_im_d[i] = dl_im_q[i-1];
      end
      dl_re_d[0] = bf ? fold(d_re) : in_re_i;
      dl_im_d[0] = bf ? fold(d_im) : in_im_i;
      out_re_d   = bf ? fold(s_re) : head_re;
      out_im_d   = bf ? fold(s_im) : head_im;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      blk_q       <= '0;
      primed_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      for (int i = 0; i < int'(DELAY); i++) begin
        dl_re_q[i] <= '0;
        dl_im_q[i] <= '0;
      end
    end else begin
      cnt_q       <= cnt_d;
      blk_q       <= blk_d;
      primed_q    <= primed_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      dl_re_q     <= dl_re_d;
      dl_im_q     <= dl_im_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_sof_o   = out_sof_q;
  assign out_re_o    = out_re_q;
  assign out_im_o    = out_im_q;

`ifdef R2SDF_OVF_FLAG_EN
  function automatic logic sat_hit(input logic signed [PW-1:0] x);
    sat_hit = (x > MAXV) || (x < MINV);
  endfunction

  logic ovf_q, ovf_d, ovf_ev;

  // Sticky: any clamp on an accepted sample latches the flag until reset.
  always_comb begin
    ovf_ev = use_tw && (sat_hit(pr_full >>> (TW - 1)) || sat_hit(pi_full >>> (TW - 1)));
    if (SCALE == 0 && bf)
      ovf_ev = ovf_ev || sat_hit(PW'(s_re)) || sat_hit(PW'(s_im)) ||
               sat_hit(PW'(d_re)) || sat_hit(PW'(d_im));
    ovf_d = ovf_q | (in_valid_i & ovf_ev);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign ovf_o = ovf_q;
`endif

endmodule

// File: tb/tb_r2sdf_fix_stage.sv
// Scoreboard bench for r2sdf_fix_stage: three instances (stage 1 scaled, stage 2 scaled, stage 1 saturating).
`timescale 1ns/1ps
module tb_r2sdf_fix_stage;

  typedef struct {
    logic signed [15:0] re;
    logic signed [15:0] im;
    logic               sof;
  } exp_t;

  logic clk, rst, in_sof, v0, v1, v2;
  logic signed [15:0] in_re, in_im;
  logic [1:0] tw0, tw1, tw2;
  logic signed [15:0] twr0, twi0, twr1, twi1, twr2, twi2;
  logic ov0, ov1, ov2, os0, os1, os2;
  logic signed [15:0] ore0, oim0, ore1, oim1, ore2, oim2;
`ifdef R2SDF_OVF_FLAG_EN
  logic ovf0, ovf1, ovf2;
`endif

  exp_t q0[$], q1[$], q2[$];
  int checks = 0;
  int errors = 0;
  bit hold_arm = 0;

  function automatic logic signed [15:0] rom_re(input logic [1:0] k);
    case (k)
      2'd0:    rom_re = 16'sd32767;
      2'd1:    rom_re = 16'sd23170;
      2'd2:    rom_re = 16'sd0;
      default: rom_re = -16'sd23170;
    endcase
  endfunction

  function automatic logic signed [15:0] rom_im(input logic [1:0] k);
    case (k)
      2'd0:    rom_im = 16'sd0;
      2'd1:    rom_im = -16'sd23170;
      2'd2:    rom_im = 16'sh8000;
      default: rom_im = -16'sd23170;
    endcase
  endfunction

  assign twr0 = rom_re(tw0); assign twi0 = rom_im(tw0);
  assign twr1 = rom_re(tw1); assign twi1 = rom_im(tw1);
  assign twr2 = rom_re(tw2); assign twi2 = rom_im(tw2);

  r2sdf_fix_stage #(.N(3), .STAGE(1), .DW(16), .TW(16), .SCALE(1)) dut0 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(v0), .in_sof_i(in_sof), .in_re_i(in_re), .in_im_i(in_im),
    .tw_addr_o(tw0), .tw_re_i(twr0), .tw_im_i(twi0), .out_valid_o(ov0), .out_sof_o(os0),
    .out_re_o(ore0), .out_im_o(oim0)
`ifdef R2SDF_OVF_FLAG_EN
    , .ovf_o(ovf0)
`endif
  );

  r2sdf_fix_stage #(.N(3), .STAGE(2), .DW(16), .TW(16), .SCALE(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(v1), .in_sof_i(in_sof), .in_re_i(in_re), .in_im_i(in_im),
    .tw_addr_o(tw1), .tw_re_i(twr1), .tw_im_i(twi1), .out_valid_o(ov1), .out_sof_o(os1),
    .out_re_o(ore1), .out_im_o(oim1)
`ifdef R2SDF_OVF_FLAG_EN
    , .ovf_o(ovf1)
`endif
  );

  r2sdf_fix_stage #(.N(3), .STAGE(1), .DW(16), .TW(16), .SCALE(0)) dut2 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(v2), .in_sof_i(in_sof), .in_re_i(in_re), .in_im_i(in_im),
    .tw_addr_o(tw2), .tw_re_i(twr2), .tw_im_i(twi2), .out_valid_o(ov2), .out_sof_o(os2),
    .out_re_o(ore2), .out_im_o(oim2)
`ifdef R2SDF_OVF_FLAG_EN
    , .ovf_o(ovf2)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  // Pops the next expected sample for instance d whenever it presents a valid output.
  task automatic mon(input int d, input logic v, input logic sf,
                     input logic signed [15:0] re, input logic signed [15:0] im);
    exp_t e;
    bit have;
    if (v !== 1'b1) return;
    have = 0;
    case (d)
      0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1; end
      1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1; end
    endcase
    checks++;
    if (!have) begin
      errors++;
      $display("FAIL unexpected_out_dut%0d: got re=%0d im=%0d sof=%0b, required no output", d, re, im, sf);
    end else if (re !== e.re || im !== e.im || sf !== e.sof) begin
      errors++;
      $display("FAIL out_dut%0d: got re=%0d im=%0d sof=%0b, required re=%0d im=%0d sof=%0b",
               d, re, im, sf, e.re, e.im, e.sof);
    end
  endtask

  logic pv0 = 1'b1, prst = 1'b1;
  logic signed [15:0] pre0 = '0, pim0 = '0;

  always @(negedge clk) begin
    mon(0, ov0, os0, ore0, oim0);
    if (hold_arm && !pv0 && !prst) begin
      check("hold_valid", 32'(ov0), 0);
      check("hold_re", 32'(ore0), 32'(pre0));
      check("hold_im", 32'(oim0), 32'(pim0));
    end
    pv0  = v0;
    prst = rst;
    pre0 = ore0;
    pim0 = oim0;
  end

  always @(negedge clk) mon(1, ov1, os1, ore1, oim1);
  always @(negedge clk) mon(2, ov2, os2, ore2, oim2);

  task automatic send(input int d, input int re, input int im, input bit sof,
                      input bit ev, input int er, input int ei, input bit es);
    exp_t e;
    if (ev) begin
      e.re = 16'(er); e.im = 16'(ei); e.sof = es;
      case (d)
        0:       q0.push_back(e);
        1:       q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
    in_re = 16'(re); in_im = 16'(im); in_sof = sof;
    case (d)
      0:       v0 = 1'b1;
      1:       v1 = 1'b1;
      default: v2 = 1'b1;
    endcase
    @(posedge clk); #1;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0; in_sof = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Reset with valid high on every instance: those samples must be dropped.
  task automatic do_reset();
    idle(2);
    rst = 1'b1; v0 = 1'b1; v1 = 1'b1; v2 = 1'b1; in_re = 16'sd777; in_im = -16'sd55; in_sof = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0; v0 = 1'b0; v1 = 1'b0; v2 = 1'b0; in_re = '0; in_im = '0; in_sof = 1'b0;
  endtask

  initial begin
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0; v2 = 1'b0; in_sof = 1'b0; in_re = '0; in_im = '0;
    do_reset();
    check("rst_valid0", 32'(ov0), 0);
    check("rst_valid1", 32'(ov1), 0);
    check("rst_valid2", 32'(ov2), 0);
    check("rst_sof1", 32'(os1), 0);
    check("rst_re0", 32'(ore0), 0);
    check("rst_im1", 32'(oim1), 0);
    check("rst_re2", 32'(ore2), 0);
    check("rst_tw0", 32'(tw0), 0);
    check("rst_tw1", 32'(tw1), 0);

    // Impulse of 100 then a zero frame on stage 1.
    for (int i = 0; i < 16; i++)
      send(0, (i == 0) ? 100 : 0, 0, 1'b0, i >= 4, (i == 4 || i == 8) ? 50 : 0, 0, i == 4 || i == 12);

    // Constant 1000 for two frames, frame starts flagged.
    do_reset();
    for (int i = 0; i < 16; i++)
      send(0, 1000, 0, (i % 8) == 0, i >= 4, ((i >= 4 && i < 8) || i >= 12) ? 1000 : 0, 0,
           i == 4 || i == 12);

    // Stage 2: twiddle W8^2 applied to sample 6 on the BF half of period 1.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      check($sformatf("tw_addr1_acc%0d", i), 32'(tw1), ((i % 8) >= 4) ? 2 : 0);
      send(1, (i == 6) ? 1000 : 0, 0, 1'b0, i >= 2, 0, (i == 6) ? -500 : ((i == 8) ? 500 : 0),
           i == 2 || i == 10);
    end

    // Impulse again with 3-cycle stalls after the 2nd and 6th samples.
    do_reset();
    hold_arm = 1;
    for (int i = 0; i < 16; i++) begin
      send(0, (i == 0) ? 100 : 0, 0, 1'b0, i >= 4, (i == 4 || i == 8) ? 50 : 0, 0, i == 4 || i == 12);
      if (i == 1 || i == 5) idle(3);
    end
    idle(3);
    hold_arm = 0;

    // Saturating stage: 32767+32767 clamps; then a mid-frame resync at sample 10.
    do_reset();
    for (int i = 0; i < 18; i++)
      send(2, (i == 0 || i == 4) ? 32767 : ((i == 10) ? 5 : 0), 0, i == 0 || i == 10, i >= 4,
           (i == 4) ? 32767 : ((i == 14) ? 5 : 0), 0, i == 4 || i == 14);
    idle(3);
`ifdef R2SDF_OVF_FLAG_EN
    check("ovf2_set", 32'(ovf2), 1);
    check("ovf0_clear", 32'(ovf0), 0);
    idle(5);
    check("ovf2_sticky", 32'(ovf2), 1);
`endif
    do_reset();
`ifdef R2SDF_OVF_FLAG_EN
    check("ovf2_rst", 32'(ovf2), 0);
`endif
    idle(4);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    check("q2_drained", q2.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
